// File: rtl/boot_pkg.sv
// Shared encodings and constants for the UART boot loader and its byte receiver.
package boot_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        LD_LEN,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizes the line, samples mid-bit, and flags
// either a good byte or a framing error with a one-cycle pulse.
module uart_rx_byte
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;
    logic             rx_meta_reg, rx_sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_sync_reg)
                    state_next = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_reg == CNT_W'(HALF - 1)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7)
                        state_next = RX_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    if (rx_sync_reg)
                        valid_next = 1'b1;
                    else
                        ferr_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_reg;
    assign byte_data  = shift_reg;
    assign frame_err  = ferr_reg;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed, big-endian word image from UART into imem and
// releases the CPU once the image is complete.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    logic [1:0]        byte_cnt_reg;
    logic [23:0]       partial_reg;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign word_valid = byte_valid && (byte_cnt_reg == 2'd3);
    assign word       = {partial_reg, byte_data};

    ld_state_t         state_reg, state_next;
    logic [ADDR_W:0]   len_reg, len_next;
    logic [ADDR_W:0]   words_reg, words_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [WORD_W-1:0] wdata_reg, wdata_next;
    logic              done_reg, done_next;
    logic              hold_reg;
    logic              err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt_reg <= '0;
            partial_reg  <= '0;
            state_reg    <= LD_LEN;
            len_reg      <= '0;
            words_reg    <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            done_reg     <= 1'b0;
            hold_reg     <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            if (byte_valid) begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
                partial_reg  <= {partial_reg[15:0], byte_data};
            end
            state_reg <= state_next;
            len_reg   <= len_next;
            words_reg <= words_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            done_reg  <= done_next;
            hold_reg  <= !done_next;
            err_reg   <= err_reg | frame_err | (state_next == LD_ERR);
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        words_next = words_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            LD_LEN: begin
                if (frame_err) begin
                    state_next = LD_ERR;
                end else if (word_valid) begin
                    if (word == '0)
                        state_next = LD_DONE;
                    else if (word > WORD_W'(DEPTH))
                        state_next = LD_ERR;
                    else begin
                        len_next   = word[ADDR_W:0];
                        state_next = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (frame_err) begin
                    state_next = LD_ERR;
                end else if (word_valid) begin
                    we_next    = 1'b1;
                    addr_next  = words_reg[ADDR_W-1:0];
                    wdata_next = word;
                    words_next = words_reg + 1'b1;
                    if (words_next == len_reg)
                        state_next = LD_DONE;
                end
            end
            default: ;
        endcase
        // Release the CPU only once the final write strobe has already been issued.
        done_next = (state_next == LD_DONE) && !we_next;
    end

    assign imem_we      = we_reg;
    assign imem_addr    = addr_reg;
    assign imem_wdata   = wdata_reg;
    assign cpu_hold     = hold_reg;
    assign load_done    = done_reg;
    assign load_err     = err_reg;
    assign words_loaded = words_reg;

endmodule
